// File: rtl/avr_io_pkg.sv
// avr_io_pkg: shared I/O-space constants, bus widths and arbiter encodings
package avr_io_pkg;
  localparam int IO_ADR_W = 6;
  localparam int IO_DAT_W = 8;
  localparam logic [IO_ADR_W-1:0] RAMPZ = 6'h3B;
  localparam logic [IO_ADR_W-1:0] EIND  = 6'h3C;
  localparam logic [IO_ADR_W-1:0] SPL   = 6'h3D;
  localparam logic [IO_ADR_W-1:0] SPH   = 6'h3E;
  localparam logic [IO_ADR_W-1:0] SREG  = 6'h3F;
  typedef enum logic [1:0] {IDLE, CORE_WAIT, DBG_ACC} state_t;
  typedef enum logic {WIN_CORE, WIN_DBG} win_t;
endpackage

// File: rtl/io_wait_timer.sv
// io_wait_timer: saturating 8-bit wait counter flagging expiry at P_TIMEOUT-1
//  cp2/ireset: clock, async active-low reset; clr: zero the count; en: count up
//  expired: count has reached P_TIMEOUT-1
module io_wait_timer #(
  parameter int P_TIMEOUT = 15
) (
  input  logic cp2,
  input  logic ireset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge cp2 or negedge ireset)
    if (!ireset) cnt <= '0;
    else cnt <= clr ? '0 : (en && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
  assign expired = cnt >= 8'(P_TIMEOUT - 1);
endmodule

// File: rtl/io_bus_arb.sv
// io_bus_arb: arbitrates the 6-bit I/O space between the CPU core and the OCD master
//  core_*: zero-latency core port, core_stall holds the core while waiting
//  dbg_*:  registered req/ack debug port, dbg_din held after dbg_ack
//  io_*:   decoder/peripheral side; io_rdy stretches, io_timeout flags forced completion
module io_bus_arb
  import avr_io_pkg::*;
#(
  parameter int P_TIMEOUT        = 15,
  parameter bit P_DBG_FIXED_PRIO = 1'b0
) (
  input  logic                cp2,
  input  logic                ireset,
  input  logic [IO_ADR_W-1:0] core_adr,
  input  logic                core_iore,
  input  logic                core_iowe,
  input  logic [IO_DAT_W-1:0] core_dout,
  output logic [IO_DAT_W-1:0] core_din,
  output logic                core_stall,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [IO_ADR_W-1:0] dbg_adr,
  input  logic [IO_DAT_W-1:0] dbg_dout,
  output logic                dbg_ack,
  output logic [IO_DAT_W-1:0] dbg_din,
  output logic [IO_ADR_W-1:0] io_adr,
  output logic                io_iore,
  output logic                io_iowe,
  output logic [IO_DAT_W-1:0] io_dbusout,
  input  logic [IO_DAT_W-1:0] io_dbusin,
  input  logic                io_rdy,
  output logic                io_timeout
);
  state_t state, state_nx;
  win_t last_win, last_win_nx;
  logic [IO_ADR_W-1:0] cap_adr;
  logic [IO_DAT_W-1:0] cap_dout;
  logic cap_we, core_req, dbg_win, core_win, core_path, active, expired, tmo, done;
  assign core_req  = core_iore | core_iowe;
  // dbg_req is ignored during the ack cycle so a held request is only seen as new a cycle later
  assign dbg_win   = state == IDLE && dbg_req && !dbg_ack &&
                     (!core_req || P_DBG_FIXED_PRIO || last_win == WIN_CORE);
  assign core_win  = state == IDLE && core_req && !dbg_win;
  assign core_path = core_win || state == CORE_WAIT;
  assign active    = core_win || state != IDLE;
  assign tmo       = state != IDLE && expired && !io_rdy;
  assign done      = active && (io_rdy || tmo);
  io_wait_timer #(.P_TIMEOUT(P_TIMEOUT)) u_timer (
    .cp2(cp2), .ireset(ireset), .clr(done), .en(active && !done), .expired(expired)
  );
  always_comb begin
    state_nx    = state == IDLE ? (dbg_win ? DBG_ACC : (core_win && !io_rdy) ? CORE_WAIT : IDLE)
                                : done ? IDLE : state;
    last_win_nx = dbg_win ? WIN_DBG : core_win ? WIN_CORE : last_win;
  end
  // strobes are gated by ireset so nothing reaches the peripherals while in reset
  assign io_adr     = state == DBG_ACC ? cap_adr : core_adr;
  assign io_dbusout = state == DBG_ACC ? cap_dout : core_dout;
  assign io_iowe    = ireset && (state == DBG_ACC ? cap_we : core_path && core_iowe);
  assign io_iore    = ireset && (state == DBG_ACC ? !cap_we : core_path && core_iore && !core_iowe);
  assign core_din   = (tmo && state == CORE_WAIT) ? 8'hFF : io_dbusin;
  assign core_stall = ireset && core_req && !(core_path && done);
  assign io_timeout = tmo;
  always_ff @(posedge cp2 or negedge ireset)
    if (!ireset) begin
      state    <= IDLE;
      last_win <= WIN_DBG;
      dbg_ack  <= 1'b0;
      dbg_din  <= '0;
      cap_adr  <= '0;
      cap_we   <= 1'b0;
      cap_dout <= '0;
    end else begin
      state    <= state_nx;
      last_win <= last_win_nx;
      dbg_ack  <= state == DBG_ACC && done;
      if (dbg_win) begin
        cap_adr  <= dbg_adr;
        cap_we   <= dbg_we;
        cap_dout <= dbg_dout;
      end
      if (state == DBG_ACC && done && !cap_we) dbg_din <= tmo ? 8'hFF : io_dbusin;
    end
endmodule

// File: tb/tb_io_bus_arb.sv
// tb_io_bus_arb: directed scenarios plus a randomized run against a bus-ownership model
module tb_io_bus_arb;
  localparam int TMO = 15;
  logic cp2 = 0, ireset = 0;
  logic [5:0] core_adr = 0, dbg_adr = 0;
  logic core_iore = 0, core_iowe = 0, dbg_req = 0, dbg_we = 0, io_rdy = 0;
  logic [7:0] core_dout = 0, dbg_dout = 0, io_dbusin = 0;
  logic [7:0] core_din, dbg_din, io_dbusout, fp_core_din, fp_dbg_din, fp_io_dbusout;
  logic [5:0] io_adr, fp_io_adr;
  logic core_stall, dbg_ack, io_iore, io_iowe, io_timeout;
  logic fp_core_stall, fp_dbg_ack, fp_io_iore, fp_io_iowe, fp_io_timeout;
  int vectors = 0, errors = 0;

  io_bus_arb #(.P_TIMEOUT(TMO), .P_DBG_FIXED_PRIO(1'b0)) dut (
    .cp2(cp2), .ireset(ireset), .core_adr(core_adr), .core_iore(core_iore), .core_iowe(core_iowe),
    .core_dout(core_dout), .core_din(core_din), .core_stall(core_stall), .dbg_req(dbg_req),
    .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_dout(dbg_dout), .dbg_ack(dbg_ack), .dbg_din(dbg_din),
    .io_adr(io_adr), .io_iore(io_iore), .io_iowe(io_iowe), .io_dbusout(io_dbusout),
    .io_dbusin(io_dbusin), .io_rdy(io_rdy), .io_timeout(io_timeout));

  io_bus_arb #(.P_TIMEOUT(TMO), .P_DBG_FIXED_PRIO(1'b1)) dut_fp (
    .cp2(cp2), .ireset(ireset), .core_adr(core_adr), .core_iore(core_iore), .core_iowe(core_iowe),
    .core_dout(core_dout), .core_din(fp_core_din), .core_stall(fp_core_stall), .dbg_req(dbg_req),
    .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_dout(dbg_dout), .dbg_ack(fp_dbg_ack), .dbg_din(fp_dbg_din),
    .io_adr(fp_io_adr), .io_iore(fp_io_iore), .io_iowe(fp_io_iowe), .io_dbusout(fp_io_dbusout),
    .io_dbusin(io_dbusin), .io_rdy(io_rdy), .io_timeout(fp_io_timeout));

  always #5 cp2 = ~cp2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge cp2);
    #1;
  endtask

  task automatic do_reset;
    ireset = 0; core_iore = 0; core_iowe = 0; dbg_req = 0;
    repeat (2) @(posedge cp2);
    #1 ireset = 1;
  endtask

  // reference model: who owns the bus, how long it has waited, pending debug ack
  int owner = 0, waited = 0, n_owner, n_waited, stuck = 0;
  bit core_last = 0, ack_now = 0, n_ack, c_hold = 0, d_hold = 0;
  bit creq, e_stall, e_rd, e_wr, e_to, e_cpath;
  logic [7:0] ddin = 0, n_ddin, e_cdin, e_dout, cap_dout;
  logic [5:0] e_adr, cap_adr;
  logic cap_we;

  initial begin
    core_iore = 1;
    repeat (2) @(posedge cp2);
    #3;
    chk("rst_io_iore", io_iore, 0);
    chk("rst_io_iowe", io_iowe, 0);
    chk("rst_core_stall", core_stall, 0);
    chk("rst_dbg_ack", dbg_ack, 0);
    chk("rst_dbg_din", dbg_din, 0);
    chk("rst_io_timeout", io_timeout, 0);
    do_reset;
    // core read, peripheral ready at once
    cyc; core_adr = 6'h3F; core_iore = 1; io_rdy = 1; io_dbusin = 8'hA5; #3;
    chk("t1_core_din", core_din, 8'hA5);
    chk("t1_stall", core_stall, 0);
    chk("t1_io_iore", io_iore, 1);
    chk("t1_io_adr", io_adr, 6'h3F);
    // core write stretched by three not-ready cycles
    for (int i = 0; i < 4; i++) begin
      cyc; core_iore = 0; core_iowe = 1; core_adr = 6'h10; core_dout = 8'h5A; io_rdy = (i == 3); #3;
      chk("t2_stall", core_stall, i < 3);
      chk("t2_io_iowe", io_iowe, 1);
      chk("t2_io_dbusout", io_dbusout, 8'h5A);
    end
    cyc; core_iowe = 0; #3;
    chk("t2_io_iowe_end", io_iowe, 0);
    // same-cycle conflict under round-robin after reset: core first
    do_reset;
    cyc; core_iore = 1; core_adr = 6'h05; dbg_req = 1; dbg_we = 0; dbg_adr = 6'h07; io_rdy = 1; io_dbusin = 8'h11; #3;
    chk("t3_core_stall", core_stall, 0);
    chk("t3_core_din", core_din, 8'h11);
    chk("t3_io_adr_core", io_adr, 6'h05);
    cyc; core_iore = 0; io_dbusin = 8'h22; #3;
    chk("t3_capture_iore", io_iore, 0);
    chk("t3_capture_ack", dbg_ack, 0);
    cyc; #3;
    chk("t3_dbg_iore", io_iore, 1);
    chk("t3_dbg_adr", io_adr, 6'h07);
    chk("t3_dbg_ack_early", dbg_ack, 0);
    cyc; dbg_req = 0; #3;
    chk("t3_dbg_ack", dbg_ack, 1);
    chk("t3_dbg_din", dbg_din, 8'h22);
    cyc; #3;
    chk("t3_ack_pulse", dbg_ack, 0);
    chk("t3_dbg_din_held", dbg_din, 8'h22);
    // fixed priority: debug wins every conflict
    do_reset;
    for (int k = 0; k < 3; k++) begin
      cyc; core_iore = 1; core_adr = 6'h01; dbg_req = 1; dbg_we = 1; dbg_adr = 6'h02;
      dbg_dout = 8'h60 + 8'(k); io_rdy = 1; #3;
      chk("t4_win_stall", fp_core_stall, 1);
      chk("t4_win_iowe", fp_io_iowe, 0);
      cyc; #3;
      chk("t4_acc_stall", fp_core_stall, 1);
      chk("t4_acc_iowe", fp_io_iowe, 1);
      chk("t4_acc_adr", fp_io_adr, 6'h02);
      chk("t4_acc_dout", fp_io_dbusout, 8'h60 + 8'(k));
      cyc; #3;
      chk("t4_ack", fp_dbg_ack, 1);
      chk("t4_core_served", fp_core_stall, 0);
      chk("t4_dbg_din_write", fp_dbg_din, 0);
    end
    // timeout with io_rdy stuck low
    do_reset;
    for (int i = 1; i <= TMO; i++) begin
      cyc; core_iore = 1; core_adr = 6'h3E; io_rdy = 0; io_dbusin = 8'h33; #3;
      chk("t5_stall", core_stall, i < TMO);
      chk("t5_timeout", io_timeout, i == TMO);
      if (i == TMO) chk("t5_core_din", core_din, 8'hFF);
    end
    cyc; core_iore = 0; #3;
    chk("t5_timeout_pulse", io_timeout, 0);
    // reset inside a debug access
    do_reset;
    cyc; dbg_req = 1; dbg_we = 0; dbg_adr = 6'h3C; io_rdy = 0; #3;
    chk("t6_capture_iore", io_iore, 0);
    cyc; #3;
    chk("t6_acc_iore", io_iore, 1);
    chk("t6_acc_adr", io_adr, 6'h3C);
    cyc; ireset = 0; dbg_req = 0; #3;
    chk("t6_rst_iore", io_iore, 0);
    chk("t6_rst_stall", core_stall, 0);
    chk("t6_rst_ack", dbg_ack, 0);
    chk("t6_rst_timeout", io_timeout, 0);
    cyc; ireset = 1;
    for (int i = 0; i < 3; i++) begin
      cyc; #3;
      chk("t6_no_ack", dbg_ack, 0);
    end
    cyc; core_iore = 1; core_adr = 6'h3D; io_rdy = 1; io_dbusin = 8'h44; #3;
    chk("t6_core_stall", core_stall, 0);
    chk("t6_core_iore", io_iore, 1);
    chk("t6_core_din", core_din, 8'h44);
    // randomized run, round-robin instance against the model
    do_reset;
    for (int n = 0; n < 3000; n++) begin
      cyc;
      if (!c_hold) begin
        case ($urandom_range(0, 3))
          0: begin core_iore = 1; core_iowe = 0; end
          1: begin core_iore = 0; core_iowe = 1; end
          default: begin core_iore = 0; core_iowe = 0; end
        endcase
        core_adr = 6'($urandom);
        core_dout = 8'($urandom);
      end
      if (!d_hold) begin
        dbg_req = $urandom_range(0, 2) == 0;
        dbg_we = 1'($urandom);
        dbg_adr = 6'($urandom);
        dbg_dout = 8'($urandom);
      end
      if (stuck > 0) begin
        io_rdy = 0;
        stuck--;
      end else begin
        io_rdy = $urandom_range(0, 3) != 0;
        if ($urandom_range(0, 63) == 0) stuck = $urandom_range(10, 20);
      end
      io_dbusin = 8'($urandom);
      #3;
      assert (!(core_iore && core_iowe)) else $error("FAIL illegal_strobes iore=%0b iowe=%0b", core_iore, core_iowe);
      creq = core_iore | core_iowe;
      e_stall = 0; e_rd = 0; e_wr = 0; e_to = 0; e_cpath = 0;
      e_cdin = io_dbusin; e_adr = core_adr; e_dout = core_dout;
      n_owner = owner; n_waited = waited; n_ack = 0; n_ddin = ddin;
      if (owner == 0) begin
        if (dbg_req && !ack_now && (!creq || core_last)) begin
          e_stall = creq; n_owner = 2; n_waited = 0; core_last = 0;
          cap_adr = dbg_adr; cap_we = dbg_we; cap_dout = dbg_dout;
        end else if (creq) begin
          e_rd = core_iore; e_wr = core_iowe; e_cpath = 1; core_last = 1;
          if (!io_rdy) begin e_stall = 1; n_owner = 1; n_waited = 1; end
        end
      end else if (owner == 1) begin
        e_rd = core_iore; e_wr = core_iowe; e_cpath = 1;
        if (io_rdy) n_owner = 0;
        else if (waited >= TMO - 1) begin e_to = 1; e_cdin = 8'hFF; n_owner = 0; end
        else begin e_stall = 1; n_waited = waited + 1; end
      end else begin
        e_adr = cap_adr; e_dout = cap_dout; e_wr = cap_we; e_rd = !cap_we; e_stall = creq;
        if (io_rdy || waited >= TMO - 1) begin
          e_to = !io_rdy; n_ack = 1; n_owner = 0;
          if (!cap_we) n_ddin = io_rdy ? io_dbusin : 8'hFF;
        end else n_waited = waited + 1;
      end
      chk("r_core_stall", core_stall, e_stall);
      chk("r_io_iore", io_iore, e_rd);
      chk("r_io_iowe", io_iowe, e_wr);
      chk("r_io_timeout", io_timeout, e_to);
      chk("r_dbg_ack", dbg_ack, ack_now);
      chk("r_dbg_din", dbg_din, ddin);
      if (e_rd || e_wr) chk("r_io_adr", io_adr, e_adr);
      if (e_wr) chk("r_io_dbusout", io_dbusout, e_dout);
      if (e_cpath && core_iore) chk("r_core_din", core_din, e_cdin);
      owner = n_owner; waited = n_waited; ack_now = n_ack; ddin = n_ddin;
      c_hold = creq && e_stall;
      d_hold = dbg_req && !dbg_ack;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
